clk_div_ctrl: RTL
=================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2: cycles the divider is held disabled before a ratio load (legal 1..15).
REQ-002 SHALL have parameter LOCK_CYC, default 4: cycles the divider runs enabled before the change is acknowledged (legal 1..15).
REQ-003 SHALL have port i_ref_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_req  input  2  per-requester ratio-change request, level, held until o_ack/o_err.
REQ-006 SHALL have ports i_ratio0 and i_ratio1  input  4 each  requested divide ratio for requester 0 and 1.
REQ-007 SHALL have port o_ack  output  2  one-cycle pulse: change applied for that requester.
REQ-008 SHALL have port o_err  output  2  one-cycle pulse: request rejected.
REQ-009 SHALL have port o_clk_enable  output  1  drives divider clock-enable.
REQ-010 SHALL have port o_div_ratio  output  4  drives divider ratio.
REQ-011 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port o_owner  output  1  index of the requester currently or last granted.

Function
REQ-013 SHALL implement FSM states IDLE, QUIESCE, LOAD, RUN_WAIT, DONE, REJECT; all outputs registered.
REQ-014 IDLE: if any i_req is high, SHALL grant one requester, latch its ratio and set o_owner; later changes to i_ratio are ignored until the next grant.
REQ-015 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; after reset requester 0 wins the first tie.
REQ-016 Ratio validity: 0 and 1 are invalid; 2..15 are valid.
REQ-017 Invalid latched ratio: IDLE->REJECT; o_err[owner]=1 for that single cycle; o_clk_enable and o_div_ratio unchanged; then ->IDLE.
REQ-018 Fast path: latched ratio equals o_div_ratio and o_clk_enable=1: IDLE->DONE directly, no disable.
REQ-019 Normal path: IDLE->QUIESCE, o_clk_enable=0 for exactly SETTLE_CYC cycles.
REQ-020 QUIESCE->LOAD: o_div_ratio takes the latched ratio; o_clk_enable stays 0 for this 1 cycle.
REQ-021 LOAD->RUN_WAIT: o_clk_enable=1 for exactly LOCK_CYC cycles, then ->DONE.
REQ-022 DONE: o_ack[owner]=1 for 1 cycle, o_clk_enable=1, then ->IDLE.
REQ-023 Latency: request sampled in IDLE at cycle N; o_ack high at cycle N+SETTLE_CYC+LOCK_CYC+2 on the normal path, N+1 on the fast path, N+1 for o_err.
REQ-024 Requests arriving while o_busy=1 SHALL wait; a requester dropping i_req mid-sequence SHALL NOT abort it, and o_ack still pulses.
REQ-025 o_ack and o_err SHALL be mutually exclusive and at most one bit set per cycle.
REQ-026 The state counter SHALL be 4 bits and SHALL reset to 0 on every state entry.

Reset
REQ-027 While i_rst_n=0 at a clock edge, SHALL go to IDLE with o_clk_enable=0, o_div_ratio=0, o_ack=0, o_err=0, o_busy=0, o_owner=0, round-robin pointer favouring 0.
REQ-028 Reset asserted mid-sequence SHALL abandon the sequence with no o_ack or o_err pulse.

Configuration
REQ-029 Macro CLK_DIV_CTRL_ERR_EN defined: invalid ratios follow REQ-017.
REQ-030 Macro CLK_DIV_CTRL_ERR_EN undefined: invalid ratios are clamped to 2 and take the normal or fast path; o_err is tied to 0 and the REJECT state is absent.

Verification
REQ-031 Reset, then i_req=01, i_ratio0=6 (defaults): o_clk_enable low cycles 1-2, o_div_ratio=6 at cycle 3, o_clk_enable high from 4, o_ack=01 at cycle 8.
REQ-032 i_req=11 simultaneously, ratios 4 and 8: requester 0 acked first (o_div_ratio=4), then requester 1 (o_div_ratio=8); repeating with i_req=11 grants 0 then 1 again, alternating from the last granted.
REQ-033 After ratio 6 is applied, request ratio 6 again: o_ack at cycle N+1, o_clk_enable never drops.
REQ-034 With ERR_EN defined, request ratio 1: o_err pulse at N+1, outputs unchanged; with ERR_EN undefined, o_div_ratio=2 and o_ack follows normal timing.
REQ-035 Assert i_rst_n=0 during RUN_WAIT: next cycle o_clk_enable=0, o_div_ratio=0, o_busy=0, no o_ack.
REQ-036 Drop i_req in QUIESCE: sequence completes and o_ack still pulses at cycle 8.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: sequences divider ratio changes (disable, load, relock, acknowledge) for two requesters
// Ports: i_ref_clk clock; i_rst_n sync active-low reset; i_req/i_ratio0/i_ratio1 requests;
//        o_ack/o_err one-cycle responses; o_clk_enable/o_div_ratio divider controls;
//        o_busy sequence in progress; o_owner last granted requester.
// Macro CLK_DIV_CTRL_ERR_EN: reject invalid ratios with o_err; otherwise clamp them to 2.
module clk_div_ctrl #(
   parameter int SETTLE_CYC = 2,
   parameter int LOCK_CYC   = 4
) (
   input  logic       i_ref_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   input  logic [3:0] i_ratio0,
   input  logic [3:0] i_ratio1,
   output logic [1:0] o_ack,
   output logic [1:0] o_err,
   output logic       o_clk_enable,
   output logic [3:0] o_div_ratio,
   output logic       o_busy,
   output logic       o_owner
);
   typedef enum logic [2:0] {
      IDLE, QUIESCE, LOAD, RUN_WAIT, DONE
`ifdef CLK_DIV_CTRL_ERR_EN
      , REJECT
`endif
   } state_t;
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d, ratio_q, ratio_d, div_q, div_d, eff;
   logic [1:0] ack_q, ack_d, err_q, err_d;
   logic       en_q, en_d, busy_q, busy_d, owner_q, owner_d, prio_q, prio_d, gnt, bad;
   assign gnt = (i_req == 2'b11) ? prio_q : i_req[1];
   assign bad = (gnt ? i_ratio1 : i_ratio0) < 4'd2;
`ifdef CLK_DIV_CTRL_ERR_EN
   assign eff = gnt ? i_ratio1 : i_ratio0;
`else
   assign eff = bad ? 4'd2 : (gnt ? i_ratio1 : i_ratio0);
`endif
   always_comb begin
      state_d = state_q;
      ratio_d = ratio_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      case (state_q)
         IDLE: if (|i_req) begin
            owner_d = gnt;
            prio_d  = ~gnt;
            ratio_d = eff;
`ifdef CLK_DIV_CTRL_ERR_EN
            state_d = bad ? REJECT : (en_q && eff == div_q) ? DONE : QUIESCE;
`else
            state_d = (en_q && eff == div_q) ? DONE : QUIESCE;
`endif
         end
         QUIESCE:  state_d = (cnt_q == 4'(SETTLE_CYC - 1)) ? LOAD : QUIESCE;
         LOAD:     state_d = RUN_WAIT;
         RUN_WAIT: state_d = (cnt_q == 4'(LOCK_CYC - 1)) ? DONE : RUN_WAIT;
         default:  state_d = IDLE;
      endcase
      // outputs are registered, so they are derived from the state being entered
      cnt_d  = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
      en_d   = (state_d == QUIESCE || state_d == LOAD) ? 1'b0 :
               (state_d == RUN_WAIT || state_d == DONE) ? 1'b1 : en_q;
      div_d  = (state_d == LOAD) ? ratio_q : div_q;
      ack_d  = (state_d == DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
`ifdef CLK_DIV_CTRL_ERR_EN
      err_d  = (state_d == REJECT) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
`else
      err_d  = 2'b00;
`endif
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge i_ref_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ratio_q <= '0;
         div_q   <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ratio_q <= ratio_d;
         div_q   <= div_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
      end
   end
   assign o_ack        = ack_q;
   assign o_err        = err_q;
   assign o_clk_enable = en_q;
   assign o_div_ratio  = div_q;
   assign o_busy       = busy_q;
   assign o_owner      = owner_q;
endmodule
